// File: rtl/pof_stream_pkg.sv
// Shared types and helpers for the sow/eow-framed rts/rtr stream blocks.
// Window FSM state encoding and the input-to-accumulator extension helper.
package pof_stream_pkg;

  localparam int EXT_MAX_W = 64;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Extends the low in_w bits of val to EXT_MAX_W, sign- or zero-filling the rest.
  function automatic logic [EXT_MAX_W-1:0] ext_to_acc(
    input logic [EXT_MAX_W-1:0] val,
    input int                   in_w,
    input bit                   is_signed
  );
    logic [EXT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i < in_w) r[i] = val[i];
      else          r[i] = is_signed ? val[in_w-1] : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_window_accumulator_if.sv
// Framed rts/rtr stream: one beat moves when rts and rtr are both high.
// The master drives the beat, the slave drives rtr.
interface stream_window_accumulator_if #(
  parameter int DW = 16
);
  logic          rts;
  logic          rtr;
  logic          sow;
  logic          eow;
  logic [DW-1:0] data;

  modport master (output rts, sow, eow, data, input rtr);
  modport slave  (input rts, sow, eow, data, output rtr);
endinterface

// File: rtl/stream_window_accumulator.sv
// Sums each sow..eow window into one single-beat result (sum, count, overflow).
// Latency 1 cycle from eow transfer to result; input stalls while an unread result is held.
module stream_window_accumulator
  import pof_stream_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  parameter bit SIGNED    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  stream_window_accumulator_if.slave   up,
  stream_window_accumulator_if.master  dn,
  output logic [CNT_WIDTH-1:0]         cnt_o,
  output logic                         ovf_o,
  output logic                         err_o
);

  state_t                 state_q, state_d;
  logic                   beat;
  logic                   load_first, accum, emit_single, emit_sum, set_err;
  logic [ACC_WIDTH-1:0]   ext_val, acc_q, sum, data_q;
  logic [ACC_WIDTH:0]     sum_full;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_inc;
  logic                   win_ovf_q, add_ovf, rts_q;

  assign up.rtr  = ~rts_q | dn.rtr;
  assign beat    = up.rts & up.rtr;
  assign dn.rts  = rts_q;
  assign dn.sow  = rts_q;
  assign dn.eow  = rts_q;
  assign dn.data = data_q;

  assign ext_val  = ACC_WIDTH'(ext_to_acc({{(EXT_MAX_W-IN_WIDTH){1'b0}}, up.data}, IN_WIDTH, SIGNED));
  assign sum_full = {1'b0, acc_q} + {1'b0, ext_val};
  assign sum      = sum_full[ACC_WIDTH-1:0];
  // Signed overflow: operands agree in sign but the result does not.
  assign add_ovf  = SIGNED ? ((acc_q[ACC_WIDTH-1] == ext_val[ACC_WIDTH-1]) &&
                              (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                           : sum_full[ACC_WIDTH];
  assign cnt_inc  = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_first  = 1'b0;
    accum       = 1'b0;
    emit_single = 1'b0;
    emit_sum    = 1'b0;
    set_err     = 1'b0;
    if (beat) begin
      if (up.sow) begin
        // A sow inside an open window abandons it and restarts here.
        set_err = (state_q == ST_ACCUM);
        if (up.eow) begin
          emit_single = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          load_first = 1'b1;
          state_d    = ST_ACCUM;
        end
      end else if (state_q == ST_IDLE) begin
        set_err = 1'b1;
      end else if (up.eow) begin
        emit_sum = 1'b1;
        state_d  = ST_IDLE;
      end else begin
        accum = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      win_ovf_q <= 1'b0;
    end else if (load_first) begin
      acc_q     <= ext_val;
      cnt_q     <= CNT_WIDTH'(1);
      win_ovf_q <= 1'b0;
    end else if (accum) begin
      acc_q     <= sum;
      cnt_q     <= cnt_inc;
      win_ovf_q <= win_ovf_q | add_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts_q  <= 1'b0;
      data_q <= '0;
      cnt_o  <= '0;
      ovf_o  <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      if (set_err) err_o <= 1'b1;
      if (emit_single) begin
        rts_q  <= 1'b1;
        data_q <= ext_val;
        cnt_o  <= CNT_WIDTH'(1);
        ovf_o  <= 1'b0;
      end else if (emit_sum) begin
        rts_q  <= 1'b1;
        data_q <= sum;
        cnt_o  <= cnt_inc;
        ovf_o  <= win_ovf_q | add_ovf;
      end else if (rts_q && dn.rtr) begin
        rts_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_window_accumulator.sv
// Directed bench: default 32-bit accumulator plus a 16-bit instance for the wrap case.
module tb_stream_window_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  stream_window_accumulator_if #(.DW(16)) a_in ();
  stream_window_accumulator_if #(.DW(32)) a_out ();
  stream_window_accumulator_if #(.DW(16)) b_in ();
  stream_window_accumulator_if #(.DW(16)) b_out ();

  logic [15:0] a_cnt, b_cnt;
  logic        a_ovf, a_err, b_ovf, b_err;

  stream_window_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(16), .SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .up(a_in), .dn(a_out),
    .cnt_o(a_cnt), .ovf_o(a_ovf), .err_o(a_err)
  );

  stream_window_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(16), .SIGNED(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .up(b_in), .dn(b_out),
    .cnt_o(b_cnt), .ovf_o(b_ovf), .err_o(b_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat at a falling edge; it transfers on the next rising edge.
  task automatic abeat(input logic s, input logic e, input logic [15:0] d);
    a_in.rts = 1'b1; a_in.sow = s; a_in.eow = e; a_in.data = d;
    @(negedge clk);
    a_in.rts = 1'b0; a_in.sow = 1'b0; a_in.eow = 1'b0;
  endtask

  task automatic bbeat(input logic s, input logic e, input logic [15:0] d);
    b_in.rts = 1'b1; b_in.sow = s; b_in.eow = e; b_in.data = d;
    @(negedge clk);
    b_in.rts = 1'b0; b_in.sow = 1'b0; b_in.eow = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in.rts = 1'b0; a_in.sow = 1'b0; a_in.eow = 1'b0; a_in.data = '0;
    b_in.rts = 1'b0; b_in.sow = 1'b0; b_in.eow = 1'b0; b_in.data = '0;
    a_out.rtr = 1'b1;
    b_out.rtr = 1'b1;

    @(negedge clk);
    chk("rst_rts",  a_out.rts,  1'b0);
    chk("rst_data", a_out.data, 32'd0);
    chk("rst_cnt",  a_cnt,      16'd0);
    chk("rst_ovf",  a_ovf,      1'b0);
    chk("rst_err",  a_err,      1'b0);
    chk("rst_rtr",  a_in.rtr,   1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-element window 3+4+5
    abeat(1'b1, 1'b0, 16'd3);
    abeat(1'b0, 1'b0, 16'd4);
    chk("w3_no_early_rts", a_out.rts, 1'b0);
    abeat(1'b0, 1'b1, 16'd5);
    chk("w3_rts",  a_out.rts,  1'b1);
    chk("w3_sow",  a_out.sow,  1'b1);
    chk("w3_eow",  a_out.eow,  1'b1);
    chk("w3_data", a_out.data, 32'd12);
    chk("w3_cnt",  a_cnt,      16'd3);
    chk("w3_ovf",  a_ovf,      1'b0);
    @(negedge clk);
    chk("w3_consumed", a_out.rts, 1'b0);

    // Ten back-to-back single-element windows of -7
    a_in.rts = 1'b1; a_in.sow = 1'b1; a_in.eow = 1'b1; a_in.data = 16'hFFF9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("b2b_rts",  a_out.rts,  1'b1);
      chk("b2b_data", a_out.data, 32'hFFFF_FFF9);
      chk("b2b_cnt",  a_cnt,      16'd1);
    end
    a_in.rts = 1'b0; a_in.sow = 1'b0; a_in.eow = 1'b0;
    @(negedge clk);
    chk("b2b_drained", a_out.rts, 1'b0);

    // Held result under backpressure; a waiting beat must not be taken
    a_out.rtr = 1'b0;
    abeat(1'b1, 1'b1, 16'd9);
    chk("bp_rts", a_out.rts, 1'b1);
    a_in.rts = 1'b1; a_in.sow = 1'b1; a_in.eow = 1'b1; a_in.data = 16'd100;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rtr_low", a_in.rtr,   1'b0);
      chk("bp_hold",    a_out.data, 32'd9);
      chk("bp_rts_hi",  a_out.rts,  1'b1);
      @(negedge clk);
    end
    a_out.rtr = 1'b1;
    #1;
    chk("bp_rtr_pass", a_in.rtr, 1'b1);
    @(negedge clk);
    a_in.rts = 1'b0; a_in.sow = 1'b0; a_in.eow = 1'b0;
    chk("bp_next_rts",  a_out.rts,  1'b1);
    chk("bp_next_data", a_out.data, 32'd100);
    @(negedge clk);
    chk("bp_done_rts", a_out.rts, 1'b0);
    chk("bp_done_rtr", a_in.rtr,  1'b1);

    // Protocol errors: stray beat in IDLE, then sow inside an open window
    chk("err_clear", a_err, 1'b0);
    abeat(1'b0, 1'b0, 16'd33);
    chk("err_stray",    a_err,     1'b1);
    chk("err_no_rts",   a_out.rts, 1'b0);
    abeat(1'b1, 1'b0, 16'd2);
    abeat(1'b1, 1'b0, 16'd7);
    abeat(1'b0, 1'b1, 16'd1);
    chk("err_rts",  a_out.rts,  1'b1);
    chk("err_data", a_out.data, 32'd8);
    chk("err_cnt",  a_cnt,      16'd2);
    chk("err_sticky", a_err,    1'b1);
    @(negedge clk);

    // 16-bit accumulator wrap, then a clean window clears the flag
    bbeat(1'b1, 1'b0, 16'h7FFF);
    bbeat(1'b0, 1'b1, 16'h0001);
    chk("ovf_rts",  b_out.rts,  1'b1);
    chk("ovf_data", b_out.data, 16'h8000);
    chk("ovf_flag", b_ovf,      1'b1);
    bbeat(1'b1, 1'b0, 16'd1);
    bbeat(1'b0, 1'b1, 16'd1);
    chk("ovf2_data", b_out.data, 16'd2);
    chk("ovf2_flag", b_ovf,      1'b0);
    chk("ovf2_cnt",  b_cnt,      16'd2);
    @(negedge clk);

    // Reset in the middle of a window discards it
    abeat(1'b1, 1'b0, 16'd50);
    abeat(1'b0, 1'b0, 16'd60);
    rst_n = 1'b0;
    #1;
    chk("mrst_rts",  a_out.rts,  1'b0);
    chk("mrst_data", a_out.data, 32'd0);
    chk("mrst_cnt",  a_cnt,      16'd0);
    chk("mrst_err",  a_err,      1'b0);
    chk("mrst_rtr",  a_in.rtr,   1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    abeat(1'b1, 1'b0, 16'd5);
    abeat(1'b0, 1'b1, 16'd6);
    chk("post_rts",  a_out.rts,  1'b1);
    chk("post_data", a_out.data, 32'd11);
    chk("post_cnt",  a_cnt,      16'd2);
    chk("post_err",  a_err,      1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
